// File: rtl/prefetcher_block_queue.sv
// Tagged block queue between the prefetcher controller and memory: entries are allocated per request,
// filled by in-order read beats and handed to the slave side on a demand hit. Stats: PREFETCH_QUEUE_STATS_EN.
module prefetcher_block_queue #(
    parameter int ADDR_BITS          = 64,
    parameter int DATA_BITS          = 64,
    parameter int LOG_QUEUE_DEPTH    = 3,
    parameter int BLOCK_OFFSET_BITS  = 6,
    parameter int ALMOST_FULL_MARGIN = 2
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       flushN,
    input  logic                       allocValid,
    input  logic [ADDR_BITS-1:0]       allocAddr,
    input  logic                       memRValid,
    input  logic [DATA_BITS-1:0]       memRData,
    output logic                       memRReady,
    input  logic                       lookupValid,
    input  logic [ADDR_BITS-1:0]       lookupAddr,
    output logic                       lookupReady,
    output logic                       prefetcherHit,
    output logic                       respValid,
    output logic [DATA_BITS-1:0]       respData,
    input  logic                       respReady,
    output logic                       almostFull,
    output logic                       full,
    output logic [LOG_QUEUE_DEPTH:0]   outstandingReqCnt,
    output logic                       overflowErr,
    output logic [31:0]                hitCount,
    output logic [31:0]                missCount
);

    localparam int QUEUE_DEPTH = 2 ** LOG_QUEUE_DEPTH;
    localparam int TAG_BITS    = ADDR_BITS - BLOCK_OFFSET_BITS;
    localparam int CNT_BITS    = LOG_QUEUE_DEPTH + 1;

    // Handshake rule: a response transfers on a cycle where respValid && respReady;
    // a lookup is taken only while lookupReady, i.e. while no claim is pending.

    logic [TAG_BITS-1:0]        tagMem  [QUEUE_DEPTH];
    logic [DATA_BITS-1:0]       dataMem [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0]     filledQ;
    logic [LOG_QUEUE_DEPTH-1:0] headQ;
    logic [LOG_QUEUE_DEPTH-1:0] tailQ;
    logic [CNT_BITS-1:0]        occQ;
    logic [CNT_BITS-1:0]        drainQ;
    logic                       claimQ;
    logic                       overflowQ;

    logic [TAG_BITS-1:0]        lookupTag;
    logic [TAG_BITS-1:0]        allocTag;
    logic                       unusedAddrBits;

    assign lookupTag      = lookupAddr[ADDR_BITS-1:BLOCK_OFFSET_BITS];
    assign allocTag       = allocAddr[ADDR_BITS-1:BLOCK_OFFSET_BITS];
    assign unusedAddrBits = ^{lookupAddr[BLOCK_OFFSET_BITS-1:0], allocAddr[BLOCK_OFFSET_BITS-1:0]};

    // Scan live entries from the head: oldest tag match and oldest unfilled entry.
    logic [LOG_QUEUE_DEPTH-1:0] scanIdx;
    logic                       matchFound;
    logic [LOG_QUEUE_DEPTH-1:0] matchOff;
    logic                       unfilledFound;
    logic [LOG_QUEUE_DEPTH-1:0] unfilledOff;
    logic [CNT_BITS-1:0]        liveUnfilled;

    always_comb begin
        scanIdx       = '0;
        matchFound    = 1'b0;
        matchOff      = '0;
        unfilledFound = 1'b0;
        unfilledOff   = '0;
        liveUnfilled  = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            scanIdx = headQ + LOG_QUEUE_DEPTH'(i);
            if (CNT_BITS'(i) < occQ) begin
                if (!filledQ[scanIdx]) begin
                    if (!unfilledFound) begin
                        unfilledFound = 1'b1;
                        unfilledOff   = LOG_QUEUE_DEPTH'(i);
                    end
                    liveUnfilled = liveUnfilled + CNT_BITS'(1);
                end
                if (!matchFound && tagMem[scanIdx] == lookupTag) begin
                    matchFound = 1'b1;
                    matchOff   = LOG_QUEUE_DEPTH'(i);
                end
            end
        end
    end

    logic                       hitNow;
    logic                       popNow;
    logic                       allocNow;
    logic                       fillTake;
    logic                       drainDec;
    logic [LOG_QUEUE_DEPTH-1:0] unfilledIdx;
    logic [LOG_QUEUE_DEPTH-1:0] allocIdx;

    assign hitNow      = lookupValid && !claimQ && matchFound;
    assign popNow      = respValid && respReady;
    assign allocNow    = allocValid && (!flushN || !full);
    assign fillTake    = memRValid && (drainQ == '0) && unfilledFound;
    assign drainDec    = memRValid && (drainQ != '0);
    assign unfilledIdx = headQ + unfilledOff;
    assign allocIdx    = flushN ? tailQ : '0;

    // Unfilled entries discarded this cycle are counted after this cycle's fill is
    // applied, so a beat that lands on a dropped entry is not owed to the drain count.
    logic [LOG_QUEUE_DEPTH-1:0] postIdx;
    logic                       postFilled;
    logic [CNT_BITS-1:0]        dropUnfilled;
    logic [CNT_BITS-1:0]        flushUnfilled;

    always_comb begin
        postIdx       = '0;
        postFilled    = 1'b0;
        dropUnfilled  = '0;
        flushUnfilled = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            postIdx    = headQ + LOG_QUEUE_DEPTH'(i);
            postFilled = filledQ[postIdx] || (fillTake && unfilledOff == LOG_QUEUE_DEPTH'(i));
            if (CNT_BITS'(i) < occQ && !postFilled) begin
                flushUnfilled = flushUnfilled + CNT_BITS'(1);
                if (LOG_QUEUE_DEPTH'(i) < matchOff) begin
                    dropUnfilled = dropUnfilled + CNT_BITS'(1);
                end
            end
        end
    end

    logic [CNT_BITS-1:0] drainInc;
    logic [CNT_BITS:0]   drainSum;
    logic [CNT_BITS-1:0] drainNext;
    logic [CNT_BITS-1:0] dropCnt;
    logic [CNT_BITS:0]   outSum;

    assign drainInc  = !flushN ? flushUnfilled : (hitNow ? dropUnfilled : '0);
    assign drainSum  = {1'b0, drainQ} - {{CNT_BITS{1'b0}}, drainDec} + {1'b0, drainInc};
    assign drainNext = (drainSum > (CNT_BITS + 1)'(QUEUE_DEPTH)) ? CNT_BITS'(QUEUE_DEPTH)
                                                                 : drainSum[CNT_BITS-1:0];
    // A hit drops the entries ahead of the match; a pop drops the head. They never coincide.
    assign dropCnt   = hitNow ? {1'b0, matchOff} : {{LOG_QUEUE_DEPTH{1'b0}}, popNow};
    assign outSum    = {1'b0, liveUnfilled} + {1'b0, drainQ};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            filledQ   <= '0;
            headQ     <= '0;
            tailQ     <= '0;
            occQ      <= '0;
            drainQ    <= '0;
            claimQ    <= 1'b0;
            overflowQ <= 1'b0;
        end else begin
            if (fillTake) begin
                filledQ[unfilledIdx] <= 1'b1;
            end
            if (allocNow) begin
                filledQ[allocIdx] <= 1'b0;
            end
            if (!flushN) begin
                headQ  <= '0;
                tailQ  <= LOG_QUEUE_DEPTH'(allocNow);
                occQ   <= CNT_BITS'(allocNow);
                claimQ <= 1'b0;
            end else begin
                headQ <= headQ + dropCnt[LOG_QUEUE_DEPTH-1:0];
                tailQ <= tailQ + LOG_QUEUE_DEPTH'(allocNow);
                occQ  <= occQ - dropCnt + CNT_BITS'(allocNow);
                if (popNow) begin
                    claimQ <= 1'b0;
                end else if (hitNow) begin
                    claimQ <= 1'b1;
                end
            end
            drainQ <= drainNext;
            if (allocValid && flushN && full) begin
                overflowQ <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (allocNow) begin
            tagMem[allocIdx] <= allocTag;
        end
        if (fillTake) begin
            dataMem[unfilledIdx] <= memRData;
        end
    end

    assign memRReady         = 1'b1;
    assign lookupReady       = !claimQ;
    assign prefetcherHit     = hitNow;
    assign respValid         = claimQ && filledQ[headQ];
    assign respData          = dataMem[headQ];
    assign full              = occQ[CNT_BITS-1];
    assign almostFull        = (CNT_BITS'(QUEUE_DEPTH) - occQ) <= CNT_BITS'(ALMOST_FULL_MARGIN);
    assign outstandingReqCnt = outSum[CNT_BITS] ? '1 : outSum[CNT_BITS-1:0];
    assign overflowErr       = overflowQ;

`ifdef PREFETCH_QUEUE_STATS_EN
    logic [31:0] hitQ;
    logic [31:0] missQ;
    logic        lookupTaken;

    assign lookupTaken = lookupValid && !claimQ;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hitQ  <= '0;
            missQ <= '0;
        end else begin
            if (hitNow) begin
                hitQ <= hitQ + 32'd1;
            end
            if (lookupTaken && !matchFound) begin
                missQ <= missQ + 32'd1;
            end
        end
    end

    assign hitCount  = hitQ;
    assign missCount = missQ;
`else
    assign hitCount  = '0;
    assign missCount = '0;
`endif

endmodule

// File: tb/tb_prefetcher_block_queue.sv
// Bench for prefetcher_block_queue: scripted vector table, hand-written corner sequences and a
// randomized run against a queue-level reference model.
module tb_prefetcher_block_queue;

    localparam int QD = 8;

    logic        clk = 1'b0;
    logic        resetN, flushN, allocValid, memRValid, lookupValid, respReady;
    logic [63:0] allocAddr, memRData, lookupAddr;
    logic        memRReady, lookupReady, prefetcherHit, respValid, almostFull, full, overflowErr;
    logic [63:0] respData;
    logic [3:0]  outstandingReqCnt;
    logic [31:0] hitCount, missCount;

    prefetcher_block_queue dut (
        .clk(clk), .resetN(resetN), .flushN(flushN),
        .allocValid(allocValid), .allocAddr(allocAddr),
        .memRValid(memRValid), .memRData(memRData), .memRReady(memRReady),
        .lookupValid(lookupValid), .lookupAddr(lookupAddr), .lookupReady(lookupReady),
        .prefetcherHit(prefetcherHit), .respValid(respValid), .respData(respData),
        .respReady(respReady), .almostFull(almostFull), .full(full),
        .outstandingReqCnt(outstandingReqCnt), .overflowErr(overflowErr),
        .hitCount(hitCount), .missCount(missCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycleNo = 0;

    // Reference model: a plain FIFO of entries, oldest at index 0.
    typedef struct {
        logic [57:0] tag;
        bit          filled;
        logic [63:0] data;
    } ent_t;

    ent_t        mq[$];
    int          mDrain;
    bit          mClaim;
    bit          mOverflow;
    int unsigned mHits;
    int unsigned mMisses;

    function automatic void mReset();
        mq.delete();
        mDrain = 0;
        mClaim = 0;
        mOverflow = 0;
        mHits = 0;
        mMisses = 0;
    endfunction

    function automatic int mUnfilled();
        int n = 0;
        foreach (mq[i]) if (!mq[i].filled) n++;
        return n;
    endfunction

    function automatic int mMatch(input logic [63:0] a);
        for (int i = 0; i < mq.size(); i++) if (mq[i].tag == a[63:6]) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycleNo, act, exp);
        end
    endtask

    task automatic checkModel();
        bit hit, rv;
        int outs;
        hit  = lookupValid && !mClaim && (mMatch(lookupAddr) >= 0);
        rv   = mClaim && (mq.size() > 0) && mq[0].filled;
        outs = mUnfilled() + mDrain;
        if (outs > 15) outs = 15;
        chk("prefetcherHit", prefetcherHit, hit);
        chk("respValid", respValid, rv);
        if (rv) chk("respData", respData, mq[0].data);
        chk("lookupReady", lookupReady, !mClaim);
        chk("memRReady", memRReady, 1);
        chk("full", full, mq.size() == QD);
        chk("almostFull", almostFull, (QD - mq.size()) <= 2);
        chk("outstandingReqCnt", outstandingReqCnt, outs);
        chk("overflowErr", overflowErr, mOverflow);
`ifdef PREFETCH_QUEUE_STATS_EN
        chk("hitCount", hitCount, mHits);
        chk("missCount", missCount, mMisses);
`else
        chk("hitCount", hitCount, 0);
        chk("missCount", missCount, 0);
`endif
    endtask

    function automatic void modelUpdate();
        bit wasFull = (mq.size() == QD);
        int m = mMatch(lookupAddr);
        bit taken = lookupValid && !mClaim;
        bit hit = taken && (m >= 0);
        bit pop = mClaim && (mq.size() > 0) && mq[0].filled && respReady;
        ent_t e;
        if (memRValid) begin
            if (mDrain > 0) mDrain--;
            else begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (!mq[i].filled) begin
                        mq[i].filled = 1;
                        mq[i].data = memRData;
                        break;
                    end
                end
            end
        end
        if (taken) begin
            if (hit) mHits++;
            else mMisses++;
        end
        if (!flushN) begin
            mDrain += mUnfilled();
            mq.delete();
            mClaim = 0;
        end else if (pop) begin
            void'(mq.pop_front());
            mClaim = 0;
        end else if (hit) begin
            repeat (m) begin
                if (!mq[0].filled) mDrain++;
                void'(mq.pop_front());
            end
            mClaim = 1;
        end
        if (allocValid) begin
            if (!flushN || !wasFull) begin
                e.tag = allocAddr[63:6];
                e.filled = 0;
                e.data = '0;
                mq.push_back(e);
            end else mOverflow = 1;
        end
        if (mDrain > QD) mDrain = QD;
    endfunction

    task automatic drive(input logic av, input logic [63:0] aa, input logic mv, input logic [63:0] md,
                         input logic lv, input logic [63:0] la, input logic rr, input logic fl);
        allocValid = av; allocAddr = aa;
        memRValid = mv; memRData = md;
        lookupValid = lv; lookupAddr = la;
        respReady = rr; flushN = fl;
    endtask

    task automatic advance();
        modelUpdate();
        @(posedge clk);
        @(negedge clk);
        cycleNo++;
    endtask

    task automatic step(input logic av, input logic [63:0] aa, input logic mv, input logic [63:0] md,
                        input logic lv, input logic [63:0] la, input logic rr, input logic fl);
        drive(av, aa, mv, md, lv, la, rr, fl);
        #1;
        checkModel();
        advance();
    endtask

    task automatic doReset();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        resetN = 1'b0;
        mReset();
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    function automatic logic [63:0] randAddr();
        logic [63:0] a;
        a = (64'(32'h100 + $urandom_range(0, 11)) << 6) | 64'($urandom_range(0, 63));
        return a;
    endfunction

    typedef struct {
        logic        av;
        logic [63:0] aa;
        logic        mv;
        logic [63:0] md;
        logic        lv;
        logic [63:0] la;
        logic        eHit;
        logic        eRv;
        logic [63:0] eData;
        logic        eReady;
        logic [3:0]  eOut;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // Three allocs, three beats, hit on the middle one, release, then re-hit and a miss.
        tbl[0]  = '{1'b1, 64'h1000, 1'b0, 64'h0, 1'b0, 64'h0,    1'b0, 1'b0, 64'h0, 1'b1, 4'd0};
        tbl[1]  = '{1'b1, 64'h1040, 1'b0, 64'h0, 1'b0, 64'h0,    1'b0, 1'b0, 64'h0, 1'b1, 4'd1};
        tbl[2]  = '{1'b1, 64'h1080, 1'b0, 64'h0, 1'b0, 64'h0,    1'b0, 1'b0, 64'h0, 1'b1, 4'd2};
        tbl[3]  = '{1'b0, 64'h0,    1'b1, 64'hA, 1'b0, 64'h0,    1'b0, 1'b0, 64'h0, 1'b1, 4'd3};
        tbl[4]  = '{1'b0, 64'h0,    1'b1, 64'hB, 1'b0, 64'h0,    1'b0, 1'b0, 64'h0, 1'b1, 4'd2};
        tbl[5]  = '{1'b0, 64'h0,    1'b1, 64'hC, 1'b0, 64'h0,    1'b0, 1'b0, 64'h0, 1'b1, 4'd1};
        tbl[6]  = '{1'b0, 64'h0,    1'b0, 64'h0, 1'b1, 64'h1040, 1'b1, 1'b0, 64'h0, 1'b1, 4'd0};
        tbl[7]  = '{1'b0, 64'h0,    1'b0, 64'h0, 1'b0, 64'h0,    1'b0, 1'b1, 64'hB, 1'b0, 4'd0};
        tbl[8]  = '{1'b0, 64'h0,    1'b0, 64'h0, 1'b1, 64'h1080, 1'b1, 1'b0, 64'h0, 1'b1, 4'd0};
        tbl[9]  = '{1'b0, 64'h0,    1'b0, 64'h0, 1'b0, 64'h0,    1'b0, 1'b1, 64'hC, 1'b0, 4'd0};
        tbl[10] = '{1'b0, 64'h0,    1'b0, 64'h0, 1'b1, 64'h1000, 1'b0, 1'b0, 64'h0, 1'b1, 4'd0};

        resetN = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        mReset();
        @(negedge clk);
        #1;
        chk("rst lookupReady", lookupReady, 1);
        chk("rst memRReady", memRReady, 1);
        chk("rst respValid", respValid, 0);
        chk("rst full", full, 0);
        chk("rst almostFull", almostFull, 0);
        chk("rst outstanding", outstandingReqCnt, 0);
        chk("rst overflowErr", overflowErr, 0);
        @(negedge clk);
        resetN = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].av, tbl[i].aa, tbl[i].mv, tbl[i].md, tbl[i].lv, tbl[i].la, 1'b1, 1'b1);
            #1;
            chk($sformatf("tbl%0d hit", i), prefetcherHit, tbl[i].eHit);
            chk($sformatf("tbl%0d respValid", i), respValid, tbl[i].eRv);
            if (tbl[i].eRv) chk($sformatf("tbl%0d respData", i), respData, tbl[i].eData);
            chk($sformatf("tbl%0d lookupReady", i), lookupReady, tbl[i].eReady);
            chk($sformatf("tbl%0d outstanding", i), outstandingReqCnt, tbl[i].eOut);
            checkModel();
            advance();
        end

        // Fill to full, then one alloc too many.
        doReset();
        for (int i = 0; i <= QD; i++) begin
            drive(1, 64'h8000 + 64'(i * 64), 0, 0, 0, 0, 1, 1);
            #1;
            chk("fill almostFull", almostFull, (QD - i) <= 2);
            chk("fill full", full, i == QD);
            chk("fill overflowErr", overflowErr, 0);
            checkModel();
            advance();
        end
        drive(0, 0, 0, 0, 1, 64'h8000 + 64'(QD * 64), 1, 1);
        #1;
        chk("ovf overflowErr", overflowErr, 1);
        chk("ovf dropped lookup", prefetcherHit, 0);
        checkModel();
        advance();

        // Hit before data, beat arrives, back-pressure for three cycles.
        doReset();
        step(1, 64'h2000, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1, 64'h2000, 0, 1);
        #1;
        chk("early hit", prefetcherHit, 1);
        checkModel();
        advance();
        drive(0, 0, 1, 64'h55, 0, 0, 0, 1);
        #1;
        chk("unfilled respValid", respValid, 0);
        checkModel();
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1);
            #1;
            chk("stall respValid", respValid, 1);
            chk("stall respData", respData, 64'h55);
            checkModel();
            advance();
        end
        step(0, 0, 0, 0, 0, 0, 1, 1);
        #1;
        chk("released lookupReady", lookupReady, 1);
        chk("released respValid", respValid, 0);

        // Flush of four unfilled entries; four beats drained, the fifth fills a new entry.
        doReset();
        for (int i = 0; i < 4; i++) step(1, 64'h5000 + 64'(i * 64), 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 64'h5000, 1, 1);
        #1;
        chk("flush outstanding", outstandingReqCnt, 4);
        chk("flush cleared", prefetcherHit, 0);
        checkModel();
        advance();
        step(1, 64'h4000, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 64'hD0 + 64'(i), 0, 0, 1, 1);
        drive(0, 0, 1, 64'h77, 0, 0, 1, 1);
        #1;
        chk("drained outstanding", outstandingReqCnt, 1);
        checkModel();
        advance();
        step(0, 0, 0, 0, 1, 64'h4000, 1, 1);
        #1;
        chk("post-flush respValid", respValid, 1);
        chk("post-flush respData", respData, 64'h77);
        step(0, 0, 0, 0, 0, 0, 1, 1);

        // Miss on an empty queue.
        doReset();
        drive(0, 0, 0, 0, 1, 64'h3000, 1, 1);
        #1;
        chk("empty miss", prefetcherHit, 0);
        checkModel();
        advance();
        #1;
`ifdef PREFETCH_QUEUE_STATS_EN
        chk("missCount", missCount, 1);
`else
        chk("missCount", missCount, 0);
`endif

        // Asynchronous reset while a claim is pending and a beat is still owed.
        doReset();
        step(1, 64'h6000, 0, 0, 0, 0, 1, 1);
        step(1, 64'h6040, 1, 64'h99, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 64'h6000, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        checkModel();
        #1;
        resetN = 1'b0;
        #1;
        chk("async respValid", respValid, 0);
        chk("async lookupReady", lookupReady, 1);
        chk("async outstanding", outstandingReqCnt, 0);
        mReset();
        @(posedge clk);
        @(negedge clk);
        cycleNo++;
        resetN = 1'b1;
        step(0, 0, 1, 64'hBAD, 0, 0, 1, 1);
        step(1, 64'h6080, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1, 64'h6080, 1, 1);
        #1;
        chk("late outstanding", outstandingReqCnt, 1);
        chk("late hit", prefetcherHit, 1);
        checkModel();
        advance();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        #1;
        chk("late beat discarded", respValid, 0);
        checkModel();
        advance();

        // Randomized traffic against the model.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1) == 0, randAddr(),
                 $urandom_range(0, 2) == 0, {$urandom, $urandom},
                 $urandom_range(0, 2) == 0, randAddr(),
                 $urandom_range(0, 1) == 0, $urandom_range(0, 39) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
